// File: rtl/traf_light_monitor.sv
// Receiver/monitor for the traf_light lamp-code interface: one-hot lamp decode plus latched protocol-fault detection.
// Optional build macro TRAF_MON_FAULT_CLEAR_EN adds a fault_clear input that lets FAULT return to INIT without reset.

module traf_light_monitor #(
  parameter int MIN_GREEN_CYC = 8,
  parameter int YELLOW_CYC    = 4,
  parameter int BLINK_CYC     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       North_1,
  input  logic       North_0,
  input  logic       East_1,
  input  logic       East_0,
  input  logic       South_1,
  input  logic       South_0,
  input  logic       West_1,
  input  logic       West_0,
`ifdef TRAF_MON_FAULT_CLEAR_EN
  input  logic       fault_clear,
`endif
  output logic [2:0] lamp_N,
  output logic [2:0] lamp_E,
  output logic [2:0] lamp_S,
  output logic [2:0] lamp_W,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;

  localparam logic [1:0] CODE_R = 2'b00;
  localparam logic [1:0] CODE_Y = 2'b01;
  localparam logic [1:0] CODE_G = 2'b10;
  localparam logic [1:0] CODE_X = 2'b11;

  localparam int CNT_MAX = (MIN_GREEN_CYC > YELLOW_CYC) ? MIN_GREEN_CYC : YELLOW_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] GREEN_MIN  = CW'(MIN_GREEN_CYC);
  localparam logic [CW-1:0] YELLOW_MIN = CW'(YELLOW_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  function automatic logic [2:0] decode_lamp(input logic [1:0] code);
    case (code)
      CODE_R:  return 3'b100;
      CODE_Y:  return 3'b010;
      CODE_G:  return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [1:0] lowest_dir(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return ((from == CODE_R) && (to == CODE_G)) ||
           ((from == CODE_G) && (to == CODE_Y)) ||
           ((from == CODE_Y) && (to == CODE_R));
  endfunction

  state_t          state_q;
  logic [1:0]      cur_q   [4];
  logic [1:0]      prev_q  [4];
  logic [CW-1:0]   cnt_q   [4];
  logic [CW-1:0]   cnt_d   [4];
  logic [2:0]      lamp_q  [4];
  logic [3:0]      first_q;
  logic            fault_q;
  logic [2:0]      fault_code_q;
  logic [1:0]      fault_dir_q;
  logic            blink_q;
  logic [BW-1:0]   blink_cnt_q;

  logic [1:0]      code_s  [4];
  logic [3:0]      ill_s, nonred_s, chg_s, bad_tr_s, short_g_s, short_y_s;
  logic            conflict_s;
  logic            viol_s;
  logic [2:0]      viol_code_s;
  logic [1:0]      viol_dir_s;
  logic            clear_s;

  assign code_s[0] = {North_1, North_0};
  assign code_s[1] = {East_1, East_0};
  assign code_s[2] = {South_1, South_0};
  assign code_s[3] = {West_1, West_0};

`ifdef TRAF_MON_FAULT_CLEAR_EN
  assign clear_s = fault_clear && (nonred_s == 4'b0000);
`else
  assign clear_s = 1'b0;
`endif

  // Per-direction legality flags and next dwell count from the current/previous samples.
  always_comb begin
    ill_s     = 4'b0000;
    nonred_s  = 4'b0000;
    chg_s     = 4'b0000;
    bad_tr_s  = 4'b0000;
    short_g_s = 4'b0000;
    short_y_s = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      cnt_d[d]     = cnt_q[d];
      ill_s[d]     = (cur_q[d] == CODE_X);
      nonred_s[d]  = (cur_q[d] != CODE_R);
      chg_s[d]     = (cur_q[d] != prev_q[d]);
      bad_tr_s[d]  = chg_s[d] && !legal_step(prev_q[d], cur_q[d]);
      short_g_s[d] = chg_s[d] && !first_q[d] && (prev_q[d] == CODE_G) &&
                     (cur_q[d] == CODE_Y) && (cnt_q[d] < GREEN_MIN);
      short_y_s[d] = chg_s[d] && !first_q[d] && (prev_q[d] == CODE_Y) &&
                     (cur_q[d] == CODE_R) && (cnt_q[d] < YELLOW_MIN);
      if (chg_s[d]) begin
        cnt_d[d] = CNT_ONE;
      end else if (cnt_q[d] < CNT_SAT) begin
        cnt_d[d] = cnt_q[d] + CNT_ONE;
      end else begin
        cnt_d[d] = cnt_q[d];
      end
    end
    conflict_s = (nonred_s[0] | nonred_s[2]) & (nonred_s[1] | nonred_s[3]);
  end

  // Priority selection of the fault cause; ties resolve to the lowest direction index.
  always_comb begin
    viol_code_s = 3'd0;
    viol_dir_s  = 2'd0;
    if (|ill_s) begin
      viol_code_s = 3'd1;
      viol_dir_s  = lowest_dir(ill_s);
    end else if (conflict_s) begin
      viol_code_s = 3'd2;
      viol_dir_s  = lowest_dir(nonred_s);
    end else if (|bad_tr_s) begin
      viol_code_s = 3'd3;
      viol_dir_s  = lowest_dir(bad_tr_s);
    end else if (|short_g_s) begin
      viol_code_s = 3'd4;
      viol_dir_s  = lowest_dir(short_g_s);
    end else if (|short_y_s) begin
      viol_code_s = 3'd5;
      viol_dir_s  = lowest_dir(short_y_s);
    end else begin
      viol_code_s = 3'd0;
      viol_dir_s  = 2'd0;
    end
    viol_s = (viol_code_s != 3'd0);
  end

  // Input stage, monitor FSM, dwell tracking, fault latch and lamp drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      for (int d = 0; d < 4; d++) begin
        cur_q[d]  <= CODE_R;
        prev_q[d] <= CODE_R;
        cnt_q[d]  <= '0;
        lamp_q[d] <= 3'b100;
      end
      first_q      <= 4'b0000;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
      fault_dir_q  <= 2'd0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        cur_q[d]  <= code_s[d];
        prev_q[d] <= cur_q[d];
      end
      case (state_q)
        ST_INIT: begin
          // The first sample seeds the history so its own dwell starts at one.
          for (int d = 0; d < 4; d++) begin
            prev_q[d] <= code_s[d];
            cnt_q[d]  <= CNT_ONE;
            lamp_q[d] <= 3'b100;
          end
          first_q <= 4'b1111;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          for (int d = 0; d < 4; d++) begin
            cnt_q[d] <= cnt_d[d];
          end
          first_q <= first_q & ~chg_s;
          if (viol_s) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= viol_code_s;
            fault_dir_q  <= viol_dir_s;
            blink_q      <= 1'b1;
            blink_cnt_q  <= '0;
            for (int d = 0; d < 4; d++) begin
              lamp_q[d] <= 3'b100;
            end
          end else begin
            for (int d = 0; d < 4; d++) begin
              lamp_q[d] <= decode_lamp(cur_q[d]);
            end
          end
        end
        ST_FAULT: begin
          if (clear_s) begin
            state_q      <= ST_INIT;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
            fault_dir_q  <= 2'd0;
            for (int d = 0; d < 4; d++) begin
              lamp_q[d] <= 3'b100;
            end
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
            for (int d = 0; d < 4; d++) begin
              lamp_q[d] <= {~blink_q, 2'b00};
            end
          end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign lamp_N     = lamp_q[0];
  assign lamp_E     = lamp_q[1];
  assign lamp_S     = lamp_q[2];
  assign lamp_W     = lamp_q[3];
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_dir  = fault_dir_q;

endmodule

// File: tb/tb_traf_light_monitor.sv
// Scoreboard bench for traf_light_monitor: directed scenarios then randomized traffic against a behavioural model.
module tb_traf_light_monitor;
  localparam int MIN_G = 8;
  localparam int YEL   = 4;
  localparam int BLINK = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0][1:0] code_x = '0;
`ifdef TRAF_MON_FAULT_CLEAR_EN
  logic clear = 1'b0;
`endif
  logic [2:0] lamp_N, lamp_E, lamp_S, lamp_W;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;

  traf_light_monitor #(.MIN_GREEN_CYC(MIN_G), .YELLOW_CYC(YEL), .BLINK_CYC(BLINK)) dut (
    .clk(clk), .reset(reset),
    .North_1(code_x[0][1]), .North_0(code_x[0][0]),
    .East_1(code_x[1][1]),  .East_0(code_x[1][0]),
    .South_1(code_x[2][1]), .South_0(code_x[2][0]),
    .West_1(code_x[3][1]),  .West_0(code_x[3][0]),
`ifdef TRAF_MON_FAULT_CLEAR_EN
    .fault_clear(clear),
`endif
    .lamp_N(lamp_N), .lamp_E(lamp_E), .lamp_S(lamp_S), .lamp_W(lamp_W),
    .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         tag;
    logic [11:0] lamps;
    logic       f;
    logic [2:0] code;
    logic [1:0] dir;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // Reference model: 0 = init, 1 = run, 2 = fault; dwell lengths kept as plain integers.
  int         m_mode = 0;
  logic [1:0] m_pend [4];
  logic [1:0] m_last [4];
  int         m_run  [4];
  bit         m_chg  [4];
  logic       m_f = 1'b0;
  logic [2:0] m_code = 3'd0;
  logic [1:0] m_dir = 2'd0;
  int         m_age = 0;
  logic [2:0] m_lamp [4];

  function automatic logic [2:0] lamp_of(input logic [1:0] c);
    if (c == 2'd1) return 3'b010;
    if (c == 2'd2) return 3'b001;
    return 3'b100;
  endfunction

  task automatic set_lamps(input logic [2:0] v);
    for (int d = 0; d < 4; d++) m_lamp[d] = v;
  endtask

  task automatic model_eval();
    logic [3:0] ill, nr, bad, sg, sy, conf;
    logic [3:0] lv [6];
    logic [1:0] p;
    int code, dir;
    for (int d = 0; d < 4; d++) begin
      p = m_pend[d];
      ill[d] = (p == 2'd3);
      nr[d] = (p != 2'd0);
      bad[d] = 1'b0; sg[d] = 1'b0; sy[d] = 1'b0;
      if (p != m_last[d]) begin
        bad[d] = !((m_last[d] == 2'd0 && p == 2'd2) || (m_last[d] == 2'd2 && p == 2'd1) ||
                   (m_last[d] == 2'd1 && p == 2'd0));
        sg[d] = m_chg[d] && m_last[d] == 2'd2 && p == 2'd1 && m_run[d] < MIN_G;
        sy[d] = m_chg[d] && m_last[d] == 2'd1 && p == 2'd0 && m_run[d] < YEL;
        m_last[d] = p; m_run[d] = 1; m_chg[d] = 1'b1;
      end else begin
        m_run[d] = m_run[d] + 1;
      end
    end
    conf = ((nr[0] | nr[2]) && (nr[1] | nr[3])) ? nr : 4'b0000;
    lv[0] = 4'b0000; lv[1] = ill; lv[2] = conf; lv[3] = bad; lv[4] = sg; lv[5] = sy;
    code = 0; dir = 0;
    for (int l = 1; l <= 5; l++) begin
      if (code == 0 && lv[l] != 4'b0000) begin
        code = l;
        for (int d = 3; d >= 0; d--) if (lv[l][d]) dir = d;
      end
    end
    if (code != 0) begin
      m_mode = 2; m_f = 1'b1; m_code = 3'(code); m_dir = 2'(dir); m_age = 0;
      set_lamps(3'b100);
    end else begin
      for (int d = 0; d < 4; d++) m_lamp[d] = lamp_of(m_pend[d]);
    end
  endtask

  task automatic model_edge(input logic [3:0][1:0] x, input bit rst, input bit clr);
    if (rst) begin
      m_mode = 0; m_f = 1'b0; m_code = 3'd0; m_dir = 2'd0;
      set_lamps(3'b100);
      for (int d = 0; d < 4; d++) m_pend[d] = 2'd0;
    end else begin
      if (m_mode == 0) begin
        for (int d = 0; d < 4; d++) begin
          m_last[d] = x[d]; m_run[d] = 0; m_chg[d] = 1'b0;
        end
        m_mode = 1;
        set_lamps(3'b100);
      end else if (m_mode == 1) begin
        model_eval();
      end else if (clr && m_pend[0] == 2'd0 && m_pend[1] == 2'd0 && m_pend[2] == 2'd0 && m_pend[3] == 2'd0) begin
        m_mode = 0; m_f = 1'b0; m_code = 3'd0; m_dir = 2'd0;
        set_lamps(3'b100);
      end else begin
        m_age = m_age + 1;
        set_lamps(((m_age / BLINK) % 2 == 0) ? 3'b100 : 3'b000);
      end
      for (int d = 0; d < 4; d++) m_pend[d] = x[d];
    end
  endtask

  task automatic step(input logic [1:0] n, input logic [1:0] e, input logic [1:0] s,
                      input logic [1:0] w, input bit rst, input bit clr);
    exp_t ex;
    logic [3:0][1:0] x;
    @(negedge clk);
    x = {w, s, e, n};
    code_x = x;
    reset = rst;
`ifdef TRAF_MON_FAULT_CLEAR_EN
    clear = clr;
`endif
    model_edge(x, rst, clr);
    ex.tag = edge_cnt + 1;
    ex.lamps = {m_lamp[3], m_lamp[2], m_lamp[1], m_lamp[0]};
    ex.f = m_f; ex.code = m_code; ex.dir = m_dir;
    exp_q.push_back(ex);
  endtask

  // Monitor: compares DUT outputs just after each edge against the expectation queued for that edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
      #1;
      while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
        ex = exp_q.pop_front();
        checks = checks + 1;
        if (ex.tag != edge_cnt || {lamp_W, lamp_S, lamp_E, lamp_N} !== ex.lamps) begin
          errors = errors + 1;
          $display("FAIL lamps edge %0d: got %b required %b", ex.tag, {lamp_W, lamp_S, lamp_E, lamp_N}, ex.lamps);
        end
        checks = checks + 1;
        if ({fault, fault_code, fault_dir} !== {ex.f, ex.code, ex.dir}) begin
          errors = errors + 1;
          $display("FAIL fault edge %0d: got f=%b code=%0d dir=%0d required f=%b code=%0d dir=%0d",
                   ex.tag, fault, fault_code, fault_dir, ex.f, ex.code, ex.dir);
        end
      end
    end
  end

  initial begin
    int axis, ph, left, idx;
    logic [1:0] c;
    logic [3:0][1:0] x;
    bit rst;
    repeat (5) step(0, 0, 0, 0, 1, 0);
    // Legal N/S cycle, E/W red
    repeat (10) step(0, 0, 0, 0, 0, 0);
    repeat (8)  step(2, 0, 2, 0, 0, 0);
    repeat (4)  step(1, 0, 1, 0, 0, 0);
    repeat (4)  step(0, 0, 0, 0, 0, 0);
    // Conflict N green with E green, then watch the flash
    repeat (3)  step(2, 0, 0, 0, 0, 0);
    step(2, 2, 0, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0, 0, 0);
    repeat (2)  step(0, 0, 0, 0, 1, 0);
    // Illegal code on W beats S green->red
    repeat (2)  step(0, 0, 0, 0, 0, 0);
    repeat (3)  step(0, 0, 2, 0, 0, 0);
    step(0, 0, 0, 3, 0, 0);
    repeat (6)  step(0, 0, 0, 0, 0, 0);
    repeat (2)  step(0, 0, 0, 0, 1, 0);
    // Short green on E, then a full-length green
    repeat (3)  step(0, 0, 0, 0, 0, 0);
    repeat (5)  step(0, 2, 0, 0, 0, 0);
    repeat (4)  step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (3)  step(0, 0, 0, 0, 0, 0);
    repeat (8)  step(0, 2, 0, 0, 0, 0);
    repeat (4)  step(0, 1, 0, 0, 0, 0);
    repeat (3)  step(0, 0, 0, 0, 0, 0);
    // Short yellow on S, reset during the flash
    repeat (8)  step(0, 0, 2, 0, 0, 0);
    repeat (3)  step(0, 0, 1, 0, 0, 0);
    repeat (8)  step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (3)  step(0, 0, 0, 0, 0, 0);
`ifdef TRAF_MON_FAULT_CLEAR_EN
    repeat (2)  step(2, 0, 0, 0, 0, 0);
    step(2, 2, 0, 0, 0, 0);
    repeat (3)  step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (3)  step(0, 0, 0, 0, 0, 0);
    repeat (8)  step(0, 0, 2, 0, 0, 0);
    repeat (4)  step(0, 0, 1, 0, 0, 0);
    repeat (3)  step(0, 0, 0, 0, 0, 0);
`endif
    // Randomized axis-alternating traffic with occasional glitches and resets
    axis = 0; ph = 0; left = 3;
    for (int i = 0; i < 2500; i++) begin
      c = (ph == 0) ? 2'd0 : ((ph == 1) ? 2'd2 : 2'd1);
      x = '0;
      if (axis == 0) begin x[0] = c; x[2] = c; end
      else begin x[1] = c; x[3] = c; end
      if ($urandom_range(0, 149) == 0) begin
        idx = int'($urandom_range(0, 3));
        x[idx] = 2'($urandom_range(0, 3));
      end
      rst = (m_mode == 2 && m_age >= 15) || ($urandom_range(0, 599) == 0);
      step(x[0], x[1], x[2], x[3], rst, 0);
      left = left - 1;
      if (left == 0) begin
        if (ph == 0) begin ph = 1; left = int'($urandom_range(5, 11)); end
        else if (ph == 1) begin ph = 2; left = int'($urandom_range(2, 6)); end
        else begin ph = 0; axis = 1 - axis; left = int'($urandom_range(1, 4)); end
      end
    end
    repeat (2) step(0, 0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traf_light_monitor.md
Name: traf_light_monitor

Overview:
Receiving end of the traf_light lamp-code interface. Samples the four 2-bit direction codes (North/East/South/West), drives one-hot lamp outputs, and checks protocol legality: codes, transition order, minimum dwell times and cross-axis conflicts. On any violation it latches a fault and forces all directions to flashing red. Same clock domain as traf_light (50 MHz board clock).

Parameters:
MIN_GREEN_CYC, 8, minimum clock cycles a direction must hold green before leaving it (board build: 250_000_000).
YELLOW_CYC, 4, minimum clock cycles a direction must hold yellow before leaving it (board build: 100_000_000).
BLINK_CYC, 3, half-period of fault red flash in cycles (board build: 25_000_000).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
North_1, North_0  input  1 each  North code MSB/LSB
East_1, East_0  input  1 each  East code
South_1, South_0  input  1 each  South code
West_1, West_0  input  1 each  West code
lamp_N, lamp_E, lamp_S, lamp_W  output  3 each  one-hot {red,yellow,green}, bit2 = red
fault  output  1  latched violation flag
fault_code  output  3  cause of first fault (0 = none)
fault_dir  output  2  direction of first fault: N=0, E=1, S=2, W=3

Behaviour:
- Code encoding: 00 red, 01 yellow, 10 green, 11 illegal.
- Input stage: the 8 input bits are registered every cycle into cur[d]. The previous registered value is held in prev[d].
- Dwell counters: one per direction, width clog2(max(MIN_GREEN_CYC,YELLOW_CYC)+1), saturating at max.
  - Set to 1 when cur[d] differs from prev[d].
  - Otherwise incremented while below saturation.
- FSM states: INIT, RUN, FAULT.
  - INIT: entered on reset. The first registered sample loads prev and counters and moves to RUN. No checks are made in INIT.
  - RUN: checks evaluated on every registered sample.
  - FAULT: terminal until reset (see Optional Feature).
- The first dwell after INIT is exempt from minimum-time checks; a per-direction first_dwell flag clears on the first change.
- Checks and fault_code values, in priority order (1 highest):
  1 = illegal code 11.
  2 = conflict: any N/S direction non-red while any E/W direction is non-red.
  3 = illegal transition. Legal transitions are R->G, G->Y and Y->R only; G->R, Y->G and R->Y are illegal.
  4 = short green: G->Y with counter < MIN_GREEN_CYC.
  5 = short yellow: Y->R with counter < YELLOW_CYC.
- Same-priority ties go to the lowest direction index. For a conflict, fault_dir is the lowest-index non-red direction.
- Latency: a violating code present at input before edge k is captured at edge k. fault, fault_code and fault_dir update at edge k+1, and lamps enter flash at edge k+1.
- Fault outputs latch the first cause only; later violations are ignored.
- Lamps in INIT/RUN: one-hot decode of cur[d] (red=100, yellow=010, green=001); 1 cycle after capture. In INIT, before the first capture, lamps show 100.
- Code 11 lamp behaviour: it always raises fault, so lamps go to flash.
- Lamps in FAULT: yellow and green forced 0. Red toggles every BLINK_CYC cycles, starting lit on fault entry; all four directions are in phase.
- Reset values: all lamps 100, fault 0, fault_code 0, fault_dir 0, state INIT, counters 0.
- Reset asserted mid-operation, including in FAULT: everything returns to reset values on that edge.

Optional Feature:
- Macro: TRAF_MON_FAULT_CLEAR_EN.
- When defined: adds input port fault_clear (1 bit). In FAULT, if fault_clear=1 and all four cur codes are 00 on the same edge, the block goes to INIT and clears fault, fault_code and fault_dir. fault_clear is ignored otherwise.
- When undefined: no port; FAULT is left only by reset.

Test Plan:
1. Reset 5 cycles, then a legal cycle for N/S: R 10 cycles -> G 8 -> Y 4 -> R, with E/W held at R -> lamp_N follows 100/001/010/100 with 1-cycle lag; fault stays 0.
2. From RUN, N green and E driven 10 (green) at the same time -> fault=1, fault_code=2, fault_dir=0 two edges after the input; all lamps flash 100/000 with a 3-cycle half-period.
3. W driven 11 and S in G->R on the same cycle -> fault_code=1, fault_dir=3; the higher-priority cause wins.
4. E green for 5 cycles (after a prior change), then yellow -> fault_code=4, fault_dir=1. Repeat with green held 8 cycles -> no fault.
5. S yellow for 3 cycles, then red -> fault_code=5, fault_dir=2. Then assert reset during the flash -> lamps 100, fault 0 on the next edge.
6. With TRAF_MON_FAULT_CLEAR_EN defined: fault pending, fault_clear=1 while N=01 -> stays FAULT. All codes 00 and fault_clear=1 -> fault 0 next edge and state INIT; a subsequent legal sequence runs fault-free.
